// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending-write scoreboard producing the ID stall
// Optional HAZARD_WB_BYPASS_EN: a source retiring this cycle (last pending write) does not stall.
module hazard_scoreboard #(
  parameter int NREGS        = 32,
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 8,
  localparam int REG_W       = $clog2(NREGS),
  localparam int IF_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_en_rs1,
  input  logic             id_en_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_en_rd,
  input  logic             id_serialize,
  input  logic             id_advance,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_en_rd,
  input  logic             flush,
  output logic             data_hazard_ID,
  output logic             sb_empty,
  output logic [IF_W-1:0]  inflight_cnt,
  output logic             sb_error
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IF_W-1:0]  IF_MAX  = IF_W'(MAX_INFLIGHT);

  // cnt[0] stays zero forever, so x0 can never look pending
  logic [CNT_W-1:0] cnt [NREGS];

  logic issue, retire, inc_req, ovf, unf, inc, dec, same_reg;
  logic rs1_haz, rs2_haz, rd_haz, ser_haz, byp1, byp2, ser_empty;

  assign sb_empty = (inflight_cnt == '0);
  assign retire   = wb_valid & wb_en_rd & (wb_rd != '0);

  always_comb begin
    byp1      = 1'b0;
    byp2      = 1'b0;
    ser_empty = sb_empty;
`ifdef HAZARD_WB_BYPASS_EN
    byp1      = retire && (wb_rd == id_rs1) && (cnt[id_rs1] == CNT_W'(1));
    byp2      = retire && (wb_rd == id_rs2) && (cnt[id_rs2] == CNT_W'(1));
    ser_empty = sb_empty || (retire && (inflight_cnt == IF_W'(1)));
`endif
    rs1_haz = id_en_rs1 && (id_rs1 != '0) && (cnt[id_rs1] != '0) && !byp1;
    rs2_haz = id_en_rs2 && (id_rs2 != '0) && (cnt[id_rs2] != '0) && !byp2;
    rd_haz  = id_en_rd && (id_rd != '0) &&
              ((cnt[id_rd] == CNT_MAX) || (inflight_cnt == IF_MAX));
    ser_haz = id_serialize && !ser_empty;
    data_hazard_ID = id_valid && (rs1_haz || rs2_haz || rd_haz || ser_haz);
  end

  assign issue    = id_valid & id_advance & ~data_hazard_ID;
  assign inc_req  = issue & id_en_rd & (id_rd != '0);
  assign ovf      = inc_req & ((cnt[id_rd] == CNT_MAX) | (inflight_cnt == IF_MAX));
  assign unf      = retire & (cnt[wb_rd] == '0);
  assign inc      = inc_req & ~ovf;
  assign dec      = retire & ~unf;
  assign same_reg = inc & dec & (id_rd == wb_rd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
      inflight_cnt <= '0;
      sb_error     <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
      inflight_cnt <= '0;
    end else begin
      if (inc && !same_reg) cnt[id_rd] <= cnt[id_rd] + CNT_W'(1);
      if (dec && !same_reg) cnt[wb_rd] <= cnt[wb_rd] - CNT_W'(1);
      if (inc && !dec)      inflight_cnt <= inflight_cnt + IF_W'(1);
      else if (dec && !inc) inflight_cnt <= inflight_cnt - IF_W'(1);
      if (ovf || unf) sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  localparam int NREGS = 32, REG_W = 5, IF_W = 4, MAXC = 3, MAXI = 8;

  logic clk = 1'b0, reset_n = 1'b0;
  logic id_valid, id_en_rs1, id_en_rs2, id_en_rd, id_serialize, id_advance;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic wb_valid, wb_en_rd, flush;
  logic data_hazard_ID, sb_empty, sb_error;
  logic [IF_W-1:0] inflight_cnt;

  hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_en_rs1(id_en_rs1), .id_en_rs2(id_en_rs2), .id_rd(id_rd), .id_en_rd(id_en_rd),
    .id_serialize(id_serialize), .id_advance(id_advance), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_en_rd(wb_en_rd), .flush(flush), .data_hazard_ID(data_hazard_ID),
    .sb_empty(sb_empty), .inflight_cnt(inflight_cnt), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  typedef struct { bit haz; int inf; bit emp; bit err; } exp_t;
  exp_t expq[$];
  int mcnt [NREGS];
  int minf;
  bit merr;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit m_retire();
    return wb_valid && wb_en_rd && wb_rd != 0;
  endfunction

  function automatic bit m_byp(logic [REG_W-1:0] r);
`ifdef HAZARD_WB_BYPASS_EN
    return m_retire() && wb_rd == r && mcnt[r] == 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_haz();
    bit h = 0;
    bit empty_ok = (minf == 0);
`ifdef HAZARD_WB_BYPASS_EN
    if (minf == 1 && m_retire()) empty_ok = 1;
`endif
    if (!id_valid) return 0;
    if (id_en_rs1 && id_rs1 != 0 && mcnt[id_rs1] != 0 && !m_byp(id_rs1)) h = 1;
    if (id_en_rs2 && id_rs2 != 0 && mcnt[id_rs2] != 0 && !m_byp(id_rs2)) h = 1;
    if (id_en_rd && id_rd != 0 && (mcnt[id_rd] == MAXC || minf == MAXI)) h = 1;
    if (id_serialize && !empty_ok) h = 1;
    return h;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) mcnt[i] = 0;
    minf = 0;
    merr = 0;
  endtask

  task automatic cyc(string tag);
    exp_t e;
    bit iss;
    e.haz = m_haz(); e.inf = minf; e.emp = (minf == 0); e.err = merr;
    expq.push_back(e);
    @(negedge clk);
    e = expq.pop_front();
    check({tag, ".haz"}, data_hazard_ID, e.haz);
    check({tag, ".inf"}, inflight_cnt, e.inf);
    check({tag, ".emp"}, sb_empty, e.emp);
    check({tag, ".err"}, sb_error, e.err);
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < NREGS; i++) mcnt[i] = 0;
      minf = 0;
    end else begin
      iss = id_valid && id_advance && !e.haz;
      if (iss && id_en_rd && id_rd != 0) begin
        if (mcnt[id_rd] == MAXC || minf == MAXI) merr = 1;
        else begin mcnt[id_rd]++; minf++; end
      end
      if (m_retire()) begin
        if (mcnt[wb_rd] == 0) merr = 1;
        else begin mcnt[wb_rd]--; minf--; end
      end
    end
    #1;
  endtask

  task automatic id_set(bit v, int rs1, bit e1, int rs2, bit e2, int rd, bit erd, bit ser, bit adv);
    id_valid = v; id_rs1 = REG_W'(rs1); id_en_rs1 = e1; id_rs2 = REG_W'(rs2); id_en_rs2 = e2;
    id_rd = REG_W'(rd); id_en_rd = erd; id_serialize = ser; id_advance = adv;
  endtask

  task automatic wb_set(bit v, int rd, bit en);
    wb_valid = v; wb_rd = REG_W'(rd); wb_en_rd = en;
  endtask

  task automatic idle();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb_set(0, 0, 0);
    flush = 0;
  endtask

  initial begin
    idle();
    m_reset();
    #12 reset_n = 1'b1;
    @(posedge clk); #1;
    cyc("rst");

    // single producer/consumer on x5
    id_set(1, 0, 0, 0, 0, 5, 1, 0, 1); cyc("iss5");
    id_set(1, 5, 1, 0, 0, 0, 0, 0, 1); #1;
    check("r21_stall", data_hazard_ID, 1);
    check("r21_inf1", inflight_cnt, 1);
    cyc("r21_a"); cyc("r21_b");
    wb_set(1, 5, 1); #1;
`ifdef HAZARD_WB_BYPASS_EN
    check("r26_byp", data_hazard_ID, 0);
`else
    check("r26_nobyp", data_hazard_ID, 1);
`endif
    cyc("r21_wb");
    wb_set(0, 0, 0); #1;
    check("r21_clear", data_hazard_ID, 0);
    check("r21_inf0", inflight_cnt, 0);
    cyc("r21_go");

    // x0 never tracked
    id_set(1, 0, 1, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 8; i++) cyc("x0");
    check("r22_inf", inflight_cnt, 0);
    check("r22_haz", data_hazard_ID, 0);

    // in-flight limit
    for (int r = 1; r <= 8; r++) begin id_set(1, 0, 0, 0, 0, r, 1, 0, 1); cyc("fill"); end
    id_set(1, 0, 0, 0, 0, 9, 1, 0, 1); #1;
    check("r23_full_haz", data_hazard_ID, 1);
    check("r23_full_inf", inflight_cnt, 8);
    wb_set(1, 1, 1); cyc("r23_ret1");
    wb_set(0, 0, 0); #1;
    check("r23_go_haz", data_hazard_ID, 0);
    check("r23_go_inf", inflight_cnt, 7);
    cyc("r23_iss9");
    check("r23_inf8", inflight_cnt, 8);
    idle();
    for (int r = 2; r <= 9; r++) begin wb_set(1, r, 1); cyc("drain"); end
    wb_set(0, 0, 0); #1;
    check("drain_empty", sb_empty, 1);

    // serialize and flush
    id_set(1, 0, 0, 0, 0, 10, 1, 0, 1); cyc("s10");
    id_set(1, 0, 0, 0, 0, 11, 1, 0, 1); cyc("s11");
    id_set(1, 0, 0, 0, 0, 0, 0, 1, 1); #1;
    check("r24_ser_haz", data_hazard_ID, 1);
    wb_set(1, 10, 1); cyc("ser_r10");
    wb_set(1, 11, 1); cyc("ser_r11");
    wb_set(0, 0, 0); #1;
    check("r24_ser_empty", sb_empty, 1);
    check("r24_ser_go", data_hazard_ID, 0);
    cyc("ser_go");
    for (int r = 12; r <= 14; r++) begin id_set(1, 0, 0, 0, 0, r, 1, 0, 1); cyc("f"); end
    check("r24_inf3", inflight_cnt, 3);
    idle(); flush = 1;
    id_set(1, 0, 0, 0, 0, 15, 1, 0, 1); wb_set(1, 12, 1);
    cyc("flush");
    idle(); #1;
    check("r24_flush_inf", inflight_cnt, 0);
    check("r24_flush_emp", sb_empty, 1);

    // underflow is sticky
    id_set(1, 0, 0, 0, 0, 20, 1, 0, 1); cyc("i20");
    idle(); wb_set(1, 7, 1); cyc("unf7");
    wb_set(0, 0, 0); #1;
    check("r25_err", sb_error, 1);
    check("r25_inf", inflight_cnt, 1);
    cyc("unf_hold");
    flush = 1; cyc("unf_flush");
    flush = 0; #1;
    check("r25_err_flush", sb_error, 1);

    // mid-operation reset
    id_set(1, 0, 0, 0, 0, 4, 1, 0, 1); cyc("i4");
    id_set(1, 0, 0, 0, 0, 6, 1, 0, 1); cyc("i6");
    idle(); reset_n = 1'b0; #1;
    check("r17_inf", inflight_cnt, 0);
    check("r17_err", sb_error, 0);
    check("r17_emp", sb_empty, 1);
    m_reset();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    id_set(1, 4, 1, 6, 1, 0, 0, 0, 1); cyc("post_rst");

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int wr;
      id_set($urandom_range(3) != 0, $urandom_range(7), $urandom_range(1), $urandom_range(7),
             $urandom_range(1), $urandom_range(7), $urandom_range(1),
             $urandom_range(7) == 0, $urandom_range(3) != 0);
      wr = $urandom_range(7);
      wb_set(mcnt[wr] > 0 && $urandom_range(1) == 1, wr, 1'b1);
      flush = ($urandom_range(31) == 0);
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32: architectural register count; REG_W = $clog2(NREGS).
REQ-002 SHALL have parameter CNT_W, default 2: width of the per-register pending-write counter (max 2^CNT_W-1 writes in flight per register).
REQ-003 SHALL have parameter MAX_INFLIGHT, default 8: total in-flight register writes allowed; IF_W = $clog2(MAX_INFLIGHT+1).
REQ-004 SHALL have ports, one clock, reset asynchronous active-low:
  clk  in  1  clock, all state on posedge
  reset_n  in  1  asynchronous active-low reset
  id_valid  in  1  ID holds a valid instruction
  id_rs1, id_rs2  in  REG_W  source register indices
  id_en_rs1, id_en_rs2  in  1  source reads enabled
  id_rd  in  REG_W  destination index
  id_en_rd  in  1  destination write enabled
  id_serialize  in  1  ID instruction needs an empty pipeline (mret, fence)
  id_advance  in  1  downstream accepts the ID instruction this cycle
  wb_valid  in  1  WB retires a valid instruction this cycle
  wb_rd  in  REG_W  WB destination index
  wb_en_rd  in  1  WB writes wb_rd
  flush  in  1  pipeline-wide squash of every in-flight instruction
  data_hazard_ID  out  1  ID must stall (combinational)
  sb_empty  out  1  no register write in flight
  inflight_cnt  out  IF_W  number of register writes in flight
  sb_error  out  1  sticky underflow/overflow flag

Function
REQ-005 SHALL keep one CNT_W-bit counter per register 1..NREGS-1; register 0 is never tracked and never causes a hazard.
REQ-006 SHALL define issue = id_valid & id_advance & ~data_hazard_ID; retire = wb_valid & wb_en_rd & (wb_rd != 0).
REQ-007 SHALL increment cnt[id_rd] and inflight_cnt on issue when id_en_rd and id_rd != 0.
REQ-008 SHALL decrement cnt[wb_rd] and inflight_cnt on retire.
REQ-009 SHALL, on issue and retire of the same register in one cycle, leave cnt unchanged; for different registers, apply both updates; inflight_cnt nets +1, 0 or -1 accordingly.
REQ-010 SHALL assert data_hazard_ID when id_valid and any of: (id_en_rs1 & id_rs1!=0 & cnt[id_rs1]!=0); same for rs2; (id_en_rd & id_rd!=0 & cnt[id_rd] at max); (id_en_rd & id_rd!=0 & inflight_cnt==MAX_INFLIGHT); (id_serialize & ~sb_empty).
REQ-011 SHALL deassert data_hazard_ID whenever id_valid is 0.
REQ-012 SHALL drive sb_empty = (inflight_cnt == 0), combinationally from state.
REQ-013 SHALL, on retire with cnt[wb_rd]==0, hold the counter at 0, hold inflight_cnt, and set sb_error.
REQ-014 SHALL set sb_error and suppress the increment if an issue would exceed a counter maximum (only reachable when id_advance is forced with the hazard asserted).
REQ-015 SHALL, on flush, clear all counters and inflight_cnt at the next edge; flush overrides same-cycle issue and retire; sb_error is not cleared.
REQ-016 SHALL take effect on the stall one cycle after issue: the register is pending from the edge that records it.

Reset
REQ-017 SHALL, while reset_n is low, asynchronously clear all counters, inflight_cnt and sb_error; outputs then read data_hazard_ID=0 (or only as computed from ID inputs against empty state), sb_empty=1, inflight_cnt=0, sb_error=0.
REQ-018 SHALL discard in-flight state when reset is asserted mid-operation; no retire is required afterwards.

Configuration
REQ-019 SHALL, when HAZARD_WB_BYPASS_EN is defined, exclude a source from the hazard check when retire targets that source this cycle and cnt[source]==1 (WB-to-ID bypass is provided elsewhere); serialize checks then treat inflight_cnt==1 with a retire as empty.
REQ-020 SHALL, without HAZARD_WB_BYPASS_EN, stall on any nonzero counter regardless of same-cycle retire.

Verification
REQ-021 Issue add x5 (id_advance=1), next cycle ID reads rs1=x5 -> data_hazard_ID=1 until cycle after WB retires x5, then 0; inflight_cnt 1->0.
REQ-022 Issue to x0 eight times -> inflight_cnt stays 0, no hazard on rs1=x0.
REQ-023 Issue 8 writes to x1..x8 without retire, 9th with rd=x9 -> data_hazard_ID=1, inflight_cnt=8; one retire of x1 -> 9th issues next cycle.
REQ-024 id_serialize=1 with inflight_cnt=2 -> stall for both retires; sb_empty=1 -> stall drops; flush with inflight_cnt=3 -> inflight_cnt=0 next cycle.
REQ-025 Retire x7 with cnt[x7]=0 -> sb_error=1 and persists; inflight_cnt unchanged; only reset_n=0 clears it.
REQ-026 With HAZARD_WB_BYPASS_EN: cnt[x3]=1, same-cycle retire x3 and ID reads x3 -> data_hazard_ID=0; without macro -> 1.
